seg_scan_controller: RTL and testbench

Time-multiplexed scan controller for the 8-digit seven-segment display. Holds the 32-bit value to show, steps through the digits at a fixed refresh rate, and feeds one shared `bto7s` decoder per slot. Drives the board's active-low cathode and anode lines with an anti-ghosting guard band. New values commit only at frame boundaries, so the display never shows a mix of two readings. Sits between the distance/measurement logic and the display pins.

---
 rtl/seg_scan_controller.sv | 99 +++++++++
 tb/tb_seg_scan_controller.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/seg_scan_controller.sv
// seg_scan_controller: 8-digit seven-segment scanner with guard band and frame-aligned value commit
module bto7s (
    input  logic [4:0] code_in,
    output logic [6:0] seg_out
);
    always_comb begin
        case (code_in)
            5'h00:   seg_out = 7'h3F;
            5'h01:   seg_out = 7'h06;
            5'h02:   seg_out = 7'h5B;
            5'h03:   seg_out = 7'h4F;
            5'h04:   seg_out = 7'h66;
            5'h05:   seg_out = 7'h6D;
            5'h06:   seg_out = 7'h7D;
            5'h07:   seg_out = 7'h07;
            5'h08:   seg_out = 7'h7F;
            5'h09:   seg_out = 7'h6F;
            5'h0A:   seg_out = 7'h77;
            5'h0B:   seg_out = 7'h7C;
            5'h0C:   seg_out = 7'h39;
            5'h0D:   seg_out = 7'h5E;
            5'h0E:   seg_out = 7'h79;
            5'h0F:   seg_out = 7'h71;
            5'h10:   seg_out = 7'h40;
            default: seg_out = 7'h00;
        endcase
    end
endmodule

module seg_scan_controller #(
    parameter int COUNT_PERIOD = 100000,
    parameter int GUARD        = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] val_in,
    input  logic        val_valid_in,
    input  logic [7:0]  dash_mask_in,
    input  logic        lz_blank_in,
    output logic [6:0]  cat_out,
    output logic [7:0]  an_out,
    output logic        frame_out,
    output logic        pending_out
);
    localparam int CW = $clog2(COUNT_PERIOD);
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [31:0]   p_val_q, s_val_q;
    logic [7:0]    p_dash_q, s_dash_q;
    logic          p_lz_q, s_lz_q, pend_q;
    logic          last, wrap;
    logic [4:0]    sh, code;
    logic [6:0]    seg;
    always_comb begin
        last  = cnt_q == CW'(COUNT_PERIOD - 1);
        wrap  = last && idx_q == 3'd7;
        cnt_d = last ? '0 : cnt_q + 1'b1;
        idx_d = idx_q + {2'b00, last};
        sh    = {idx_q, 2'b00};
        // leading zeros: this nibble and everything above it is zero
        code  = s_dash_q[idx_q] ? 5'h10 :
                (s_lz_q && idx_q != 3'd0 && (s_val_q >> sh) == 32'd0) ? 5'h1F :
                {1'b0, s_val_q[sh +: 4]};
    end
    bto7s u_dec (.code_in(code), .seg_out(seg));
    assign pending_out = pend_q;
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            pend_q    <= 1'b0;
            p_val_q   <= '0;
            p_dash_q  <= '0;
            p_lz_q    <= 1'b0;
            s_val_q   <= '0;
            s_dash_q  <= '0;
            s_lz_q    <= 1'b0;
            cat_out   <= 7'h7F;
            an_out    <= 8'hFF;
            frame_out <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            if (wrap) begin
                pend_q <= 1'b0;
                if (val_valid_in)
                    {s_val_q, s_dash_q, s_lz_q} <= {val_in, dash_mask_in, lz_blank_in};
                else if (pend_q)
                    {s_val_q, s_dash_q, s_lz_q} <= {p_val_q, p_dash_q, p_lz_q};
            end else if (val_valid_in) begin
                {p_val_q, p_dash_q, p_lz_q} <= {val_in, dash_mask_in, lz_blank_in};
                pend_q <= 1'b1;
            end
            frame_out <= wrap;
            cat_out   <= ~seg;
            an_out    <= (cnt_q < CW'(GUARD)) ? 8'hFF : ~(8'd1 << idx_q);
        end
    end
endmodule

// File: tb/tb_seg_scan_controller.sv
// tb_seg_scan_controller: directed scenarios with COUNT_PERIOD=8, GUARD=2 (64-cycle frames)
module tb_seg_scan_controller;
    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic [31:0] val_in = '0;
    logic        val_valid_in = 1'b0;
    logic [7:0]  dash_mask_in = '0;
    logic        lz_blank_in = 1'b0;
    logic [6:0]  cat_out;
    logic [7:0]  an_out;
    logic        frame_out, pending_out;
    int checks = 0, errors = 0, cyc = 0;
    logic [6:0] seen_cat [8];
    int low_cnt [8];
    int two_low, glitch, frames, last_frame, pend_cycles;
    logic [6:0] prev_cat = 7'h7F;
    seg_scan_controller #(.COUNT_PERIOD(8), .GUARD(2)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .val_in(val_in), .val_valid_in(val_valid_in),
        .dash_mask_in(dash_mask_in), .lz_blank_in(lz_blank_in), .cat_out(cat_out),
        .an_out(an_out), .frame_out(frame_out), .pending_out(pending_out)
    );
    always #5 clk_in = ~clk_in;
    task automatic do_reset();
        @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
        val_valid_in = 1'b0;
        cyc = 0;
        prev_cat = cat_out;
    endtask
    task automatic clear_stats();
        for (int d = 0; d < 8; d++) begin
            seen_cat[d] = 7'hxx;
            low_cnt[d] = 0;
        end
        two_low = 0; glitch = 0; frames = 0; last_frame = -1; pend_cycles = 0;
    endtask
    task automatic strobe(input logic [31:0] v, input logic [7:0] d, input logic l);
        val_in = v; dash_mask_in = d; lz_blank_in = l; val_valid_in = 1'b1;
    endtask
    // advance n cycles, gathering what the display showed per digit
    task automatic scan(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk_in);
            cyc++;
            val_valid_in = 1'b0;
            for (int d = 0; d < 8; d++)
                if (!an_out[d]) begin
                    seen_cat[d] = cat_out;
                    low_cnt[d]++;
                end
            if ($countones(~an_out) > 1) two_low++;
            if (cat_out != prev_cat && an_out != 8'hFF) glitch++;
            prev_cat = cat_out;
            if (frame_out) begin frames++; last_frame = cyc; end
            if (pending_out) pend_cycles++;
        end
    endtask
    task automatic test_reset();
        do_reset();
        checks++; if (an_out !== 8'hFF) begin errors++; $display("FAIL reset_an got %h exp ff", an_out); end
        checks++; if (cat_out !== 7'h7F) begin errors++; $display("FAIL reset_cat got %h exp 7f", cat_out); end
        checks++; if (frame_out !== 1'b0) begin errors++; $display("FAIL reset_frame got %b exp 0", frame_out); end
        checks++; if (pending_out !== 1'b0) begin errors++; $display("FAIL reset_pend got %b exp 0", pending_out); end
        clear_stats(); scan(2);
        checks++; if (an_out !== 8'hFF) begin errors++; $display("FAIL guard_an got %h exp ff", an_out); end
        scan(1);
        checks++; if (an_out !== 8'hFE) begin errors++; $display("FAIL first_an got %h exp fe", an_out); end
    endtask
    task automatic test_scan();
        logic [6:0] exp_cat [8] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};
        do_reset();
        strobe(32'h76543210, 8'h00, 1'b0);
        clear_stats(); scan(64);
        checks++; if (pend_cycles !== 63) begin errors++; $display("FAIL scan_pend got %0d exp 63", pend_cycles); end
        checks++; if (frames !== 1 || last_frame !== 64) begin errors++; $display("FAIL frame0 got %0d@%0d exp 1@64", frames, last_frame); end
        for (int d = 0; d < 8; d++) begin
            checks++; if (seen_cat[d] !== 7'h40) begin errors++; $display("FAIL scan_old d%0d got %h exp 40", d, seen_cat[d]); end
        end
        clear_stats(); scan(64);
        for (int d = 0; d < 8; d++) begin
            checks++; if (seen_cat[d] !== exp_cat[d]) begin errors++; $display("FAIL scan_cat d%0d got %h exp %h", d, seen_cat[d], exp_cat[d]); end
            checks++; if (low_cnt[d] !== 6) begin errors++; $display("FAIL scan_low d%0d got %0d exp 6", d, low_cnt[d]); end
        end
        checks++; if (frames !== 1 || last_frame !== 128) begin errors++; $display("FAIL frame1 got %0d@%0d exp 1@128", frames, last_frame); end
        checks++; if (two_low !== 0) begin errors++; $display("FAIL two_low got %0d exp 0", two_low); end
        checks++; if (glitch !== 0) begin errors++; $display("FAIL glitch got %0d exp 0", glitch); end
    endtask
    task automatic test_commit_boundary();
        do_reset();
        strobe(32'h11111111, 8'h00, 1'b0);
        scan(64); clear_stats(); scan(34);
        strobe(32'h22222222, 8'h00, 1'b0);
        scan(30);
        for (int d = 0; d < 8; d++) begin
            checks++; if (seen_cat[d] !== 7'h79) begin errors++; $display("FAIL bound_old d%0d got %h exp 79", d, seen_cat[d]); end
        end
        checks++; if (pend_cycles !== 29) begin errors++; $display("FAIL bound_pend got %0d exp 29", pend_cycles); end
        clear_stats(); scan(64);
        for (int d = 0; d < 8; d++) begin
            checks++; if (seen_cat[d] !== 7'h24) begin errors++; $display("FAIL bound_new d%0d got %h exp 24", d, seen_cat[d]); end
        end
        checks++; if (pend_cycles !== 0) begin errors++; $display("FAIL bound_pend2 got %0d exp 0", pend_cycles); end
    endtask
    task automatic test_lz_dash();
        logic [6:0] exp_cat [8] = '{7'h40, 7'h12, 7'h19, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h3F};
        do_reset();
        strobe(32'h00000450, 8'h80, 1'b1);
        scan(64); clear_stats(); scan(64);
        for (int d = 0; d < 8; d++) begin
            checks++; if (seen_cat[d] !== exp_cat[d]) begin errors++; $display("FAIL lz d%0d got %h exp %h", d, seen_cat[d], exp_cat[d]); end
        end
        dash_mask_in = 8'h00; lz_blank_in = 1'b0;
    endtask
    task automatic test_collision();
        do_reset();
        clear_stats(); scan(18);
        strobe(32'hAAAAAAAA, 8'h00, 1'b0);
        scan(45);
        strobe(32'hBBBBBBBB, 8'h00, 1'b0);
        scan(1);
        checks++; if (pending_out !== 1'b0) begin errors++; $display("FAIL coll_pend got %b exp 0", pending_out); end
        checks++; if (frame_out !== 1'b1) begin errors++; $display("FAIL coll_frame got %b exp 1", frame_out); end
        for (int d = 0; d < 8; d++) begin
            checks++; if (seen_cat[d] !== 7'h40) begin errors++; $display("FAIL coll_old d%0d got %h exp 40", d, seen_cat[d]); end
        end
        clear_stats(); scan(64);
        for (int d = 0; d < 8; d++) begin
            checks++; if (seen_cat[d] !== 7'h03) begin errors++; $display("FAIL coll_new d%0d got %h exp 03", d, seen_cat[d]); end
        end
    endtask
    task automatic test_back_to_back();
        do_reset();
        scan(10);
        strobe(32'hCCCCCCCC, 8'h00, 1'b0);
        scan(20);
        strobe(32'hDDDDDDDD, 8'h00, 1'b0);
        scan(34); clear_stats(); scan(64);
        for (int d = 0; d < 8; d++) begin
            checks++; if (seen_cat[d] !== 7'h21) begin errors++; $display("FAIL b2b d%0d got %h exp 21", d, seen_cat[d]); end
        end
    endtask
    task automatic test_midframe_reset();
        do_reset();
        scan(20);
        strobe(32'hEEEEEEEE, 8'h00, 1'b0);
        scan(10);
        checks++; if (pending_out !== 1'b1) begin errors++; $display("FAIL mid_pend_pre got %b exp 1", pending_out); end
        checks++; if (an_out === 8'hFF) begin errors++; $display("FAIL mid_an_pre got %h exp not ff", an_out); end
        do_reset();
        checks++; if (an_out !== 8'hFF) begin errors++; $display("FAIL mid_an got %h exp ff", an_out); end
        checks++; if (cat_out !== 7'h7F) begin errors++; $display("FAIL mid_cat got %h exp 7f", cat_out); end
        checks++; if (pending_out !== 1'b0) begin errors++; $display("FAIL mid_pend got %b exp 0", pending_out); end
        scan(64); clear_stats(); scan(64);
        for (int d = 0; d < 8; d++) begin
            checks++; if (seen_cat[d] !== 7'h40) begin errors++; $display("FAIL mid_after d%0d got %h exp 40", d, seen_cat[d]); end
        end
    endtask
    initial begin
        test_reset();
        test_scan();
        test_commit_boundary();
        test_lz_dash();
        test_collision();
        test_back_to_back();
        test_midframe_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
